// File: rtl/hall_telemetry_packetizer.sv
// Hall-speed telemetry packetizer: on every period tick, snapshots the four
// speed counts and streams a 12-byte framed packet to the UART transmitter.
module hall_telemetry_packetizer #(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter logic [7:0]  HDR0          = 8'hAA,
  parameter logic [7:0]  HDR1          = 8'h55
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [15:0] SPEED0,
  input  logic [15:0] SPEED1,
  input  logic [15:0] SPEED2,
  input  logic [15:0] SPEED3,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        BUSY,
  output logic        PKT_DONE,
  output logic        OVERRUN
);

  localparam logic [23:0] PeriodLast = 24'(PERIOD_CYCLES - 1);
  localparam logic [3:0]  LastIdx    = 4'd11;

  typedef enum logic {StIdle, StSend} state_e;

  state_e      state_q, state_d;
  logic [23:0] period_q;
  logic        trigger;
  logic [3:0]  idx_q;
  logic [7:0]  seq_q;
  logic [15:0] snap0_q, snap1_q, snap2_q, snap3_q;
  logic [7:0]  snap_seq_q, snap_chk_q;
  logic        pkt_done_q, overrun_q;
  logic        fire, fire_last;
  logic [7:0]  chk_d;
  logic [7:0]  cur_byte;

  assign trigger   = ENABLE && (period_q == PeriodLast);
  assign fire      = (state_q == StSend) && TX_READY;
  assign fire_last = fire && (idx_q == LastIdx);

  // Checksum over SEQ and the eight speed bytes; carries drop out of the 8-bit sum.
  assign chk_d = seq_q + SPEED0[15:8] + SPEED0[7:0] + SPEED1[15:8] + SPEED1[7:0]
               + SPEED2[15:8] + SPEED2[7:0] + SPEED3[15:8] + SPEED3[7:0];

  // Period counter: held at zero while disabled, wraps on the trigger cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      period_q <= '0;
    end else if (!ENABLE || trigger) begin
      period_q <= '0;
    end else begin
      period_q <= period_q + 24'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (trigger)   state_d = StSend;
      StSend: if (fire_last) state_d = StIdle;
    endcase
  end

  // Snapshot capture and byte index; speeds are frozen for the whole packet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q      <= '0;
      snap0_q    <= '0;
      snap1_q    <= '0;
      snap2_q    <= '0;
      snap3_q    <= '0;
      snap_seq_q <= '0;
      snap_chk_q <= '0;
    end else if (state_q == StIdle && trigger) begin
      idx_q      <= '0;
      snap0_q    <= SPEED0;
      snap1_q    <= SPEED1;
      snap2_q    <= SPEED2;
      snap3_q    <= SPEED3;
      snap_seq_q <= seq_q;
      snap_chk_q <= chk_d;
    end else if (fire && !fire_last) begin
      idx_q <= idx_q + 4'd1;
    end
  end

  // Sequence number, completion pulse and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seq_q      <= '0;
      pkt_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pkt_done_q <= fire_last;
      if (fire_last) seq_q <= seq_q + 8'd1;
      // A trigger is dropped whenever a packet is still in flight.
      if (trigger && state_q != StIdle) overrun_q <= 1'b1;
    end
  end

  // Byte selection by packet index.
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      4'd0:    cur_byte = HDR0;
      4'd1:    cur_byte = HDR1;
      4'd2:    cur_byte = snap_seq_q;
      4'd3:    cur_byte = snap0_q[15:8];
      4'd4:    cur_byte = snap0_q[7:0];
      4'd5:    cur_byte = snap1_q[15:8];
      4'd6:    cur_byte = snap1_q[7:0];
      4'd7:    cur_byte = snap2_q[15:8];
      4'd8:    cur_byte = snap2_q[7:0];
      4'd9:    cur_byte = snap3_q[15:8];
      4'd10:   cur_byte = snap3_q[7:0];
      4'd11:   cur_byte = snap_chk_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // FSM outputs: the stream is valid for the whole SEND state.
  always_comb begin
    TX_VALID = 1'b0;
    BUSY     = 1'b0;
    TX_DATA  = 8'h00;
    if (state_q == StSend) begin
      TX_VALID = 1'b1;
      BUSY     = 1'b1;
      TX_DATA  = cur_byte;
    end
  end

  assign PKT_DONE = pkt_done_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_hall_telemetry_packetizer.sv
// Bench for hall_telemetry_packetizer: a transaction-level model predicts the
// byte stream and status flags; a separate monitor compares them each cycle.
module tb_hall_telemetry_packetizer;

  localparam int P = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE = 1'b0;
  logic [15:0] SPEED0 = 16'h1234, SPEED1 = 16'hABCD, SPEED2 = 16'h0001, SPEED3 = 16'hFFFF;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic        BUSY, PKT_DONE, OVERRUN;

  hall_telemetry_packetizer #(
    .PERIOD_CYCLES(P),
    .HDR0         (8'hAA),
    .HDR1         (8'h55)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ENABLE  (ENABLE),
    .SPEED0  (SPEED0),
    .SPEED1  (SPEED1),
    .SPEED2  (SPEED2),
    .SPEED3  (SPEED3),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .BUSY    (BUSY),
    .PKT_DONE(PKT_DONE),
    .OVERRUN (OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus controls owned by the driver process below.
  bit ready_rand = 1'b0;
  bit ready_fix  = 1'b1;
  bit rand_speed = 1'b0;

  always @(posedge CLK) begin
    #1;
    TX_READY = ready_rand ? ($urandom_range(0, 99) < 30) : ready_fix;
    if (rand_speed) begin
      SPEED0 = 16'($urandom);
      SPEED1 = 16'($urandom);
      SPEED2 = 16'($urandom);
      SPEED3 = 16'($urandom);
    end
  end

  // Reference model: packets are predicted from elapsed enabled cycles and
  // the number of accepted handshakes, not from the design's internals.
  logic [7:0] exp_q[$];
  int         run = 0;
  int         remaining = 0;
  logic [7:0] mseq = 8'h00;
  bit         ovr_sticky = 1'b0, done_flag = 1'b0, rst_prev = 1'b1;
  bit         exp_valid = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0;

  always @(negedge CLK) begin
    bit         trig;
    int         sum;
    logic [7:0] pkt[12];
    if (rst_prev) begin
      run = 0; remaining = 0; mseq = 8'h00; ovr_sticky = 1'b0; done_flag = 1'b0;
      exp_q.delete();
    end
    exp_valid = (remaining != 0);
    exp_done  = done_flag;
    exp_ovr   = ovr_sticky;
    done_flag = 1'b0;
    trig = 1'b0;
    if (ENABLE) begin
      trig = ((run % P) == P - 1);
      run++;
    end else begin
      run = 0;
    end
    if (remaining == 0) begin
      if (trig) begin
        pkt[0] = 8'hAA; pkt[1] = 8'h55; pkt[2] = mseq;
        pkt[3] = SPEED0[15:8]; pkt[4] = SPEED0[7:0];
        pkt[5] = SPEED1[15:8]; pkt[6] = SPEED1[7:0];
        pkt[7] = SPEED2[15:8]; pkt[8] = SPEED2[7:0];
        pkt[9] = SPEED3[15:8]; pkt[10] = SPEED3[7:0];
        sum = 0;
        for (int i = 2; i <= 10; i++) sum += int'(pkt[i]);
        pkt[11] = 8'(sum % 256);
        for (int i = 0; i < 12; i++) exp_q.push_back(pkt[i]);
        remaining = 12;
      end
    end else begin
      if (trig) ovr_sticky = 1'b1;
      if (TX_READY) begin
        remaining--;
        if (remaining == 0) begin
          mseq++;
          done_flag = 1'b1;
        end
      end
    end
    rst_prev = RST;
  end

  // Monitor: compares DUT outputs against the model just after the model runs.
  bit         started = 1'b0;
  logic [7:0] cap[$];
  int         pkt_bytes = 0;
  int         dut_pkts = 0;
  int         seq_wraps = 0;
  logic [7:0] last_seq = 8'h00;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge CLK) begin
    logic [7:0] e;
    #1;
    if (started) begin
      check("tx_valid", int'(TX_VALID), int'(exp_valid));
      check("busy", int'(BUSY), int'(exp_valid));
      check("pkt_done", int'(PKT_DONE), int'(exp_done));
      check("overrun", int'(OVERRUN), int'(exp_ovr));
      if (PKT_DONE) begin
        check("done_alignment", pkt_bytes, 0);
        dut_pkts++;
      end
      if (prev_stall && TX_VALID) check("stall_hold", int'(TX_DATA), int'(prev_data));
      if (TX_VALID && TX_READY) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", int'(TX_DATA), -1);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", int'(TX_DATA), int'(e));
        end
        if (pkt_bytes == 2) begin
          if (last_seq == 8'hFF && TX_DATA == 8'h00) seq_wraps++;
          last_seq = TX_DATA;
        end
        cap.push_back(TX_DATA);
        pkt_bytes = (pkt_bytes + 1) % 12;
      end
      prev_stall = TX_VALID && !TX_READY && !RST;
      prev_data  = TX_DATA;
      if (RST) pkt_bytes = 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int target;
    target = dut_pkts + n;
    for (int i = 0; i < budget && dut_pkts < target; i++) step();
    if (dut_pkts < target) check("wait_pkts_timeout", dut_pkts, target);
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    ENABLE = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      n++;
      if (TX_VALID) break;
    end
    check(name, n, P);
  endtask

  logic [7:0] kat[12] = '{8'hAA, 8'h55, 8'h00, 8'h12, 8'h34, 8'hAB,
                          8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hBD};

  initial begin
    int base;
    int bound;
    RST = 1'b1;
    repeat (3) step();
    started = 1'b1;
    RST = 1'b0;
    step();
    check("rst_tx_data", int'(TX_DATA), 0);
    check("rst_tx_valid", int'(TX_VALID), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_pkt_done", int'(PKT_DONE), 0);
    check("rst_overrun", int'(OVERRUN), 0);

    // Known-answer packet with back-to-back transfer, then SEQ advances.
    cap.delete();
    measure_latency("first_trigger_latency");
    wait_pkts(1, 100);
    for (int i = 0; i < 12; i++) begin
      if (cap.size() > i) check($sformatf("kat_byte%0d", i), int'(cap[i]), int'(kat[i]));
      else check("kat_missing", cap.size(), 12);
    end
    wait_pkts(1, 100);
    if (cap.size() > 14) check("second_seq", int'(cap[14]), 1);
    else check("second_missing", cap.size(), 24);
    check("no_overrun_yet", int'(OVERRUN), 0);

    // Long stall across the next trigger.
    bound = 0;
    while (!TX_VALID && bound < 100) begin
      step();
      bound++;
    end
    ready_fix = 1'b0;
    repeat (40) step();
    ready_fix = 1'b1;
    wait_pkts(1, 100);
    check("overrun_set", int'(OVERRUN), 1);

    // Random backpressure and speeds changing every cycle.
    rand_speed = 1'b1;
    ready_rand = 1'b1;
    wait_pkts(6, 3000);
    check("overrun_sticky", int'(OVERRUN), 1);

    // Reset in the middle of a packet.
    ready_rand = 1'b0;
    ready_fix  = 1'b1;
    wait_pkts(1, 500);
    bound = 0;
    while (pkt_bytes != 5 && bound < 200) begin
      step();
      bound++;
    end
    check("reach_idx5", pkt_bytes, 5);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort_valid", int'(TX_VALID), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_overrun", int'(OVERRUN), 0);
    cap.delete();
    wait_pkts(1, 100);
    if (cap.size() >= 12) begin
      check("post_rst_hdr0", int'(cap[0]), 8'hAA);
      check("post_rst_seq", int'(cap[2]), 0);
    end else begin
      check("post_rst_missing", cap.size(), 12);
    end

    // Enough packets to wrap SEQ.
    wait_pkts(260, 260 * P + 200);
    check("seq_wrapped", int'(seq_wraps >= 1), 1);

    // Disable: no more triggers; counter restarts from zero.
    ENABLE = 1'b0;
    bound = 0;
    while (BUSY && bound < 50) begin
      step();
      bound++;
    end
    repeat (2) step();
    base = dut_pkts;
    repeat (100) step();
    check("disabled_no_pkts", dut_pkts, base);
    check("disabled_idle", int'(TX_VALID), 0);
    measure_latency("reenable_latency");
    wait_pkts(1, 100);
    step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hall_telemetry_packetizer.md
# hall_telemetry_packetizer

Periodically snapshots the four 16-bit hall-speed measurements and frames them into a fixed 12-byte telemetry packet. The packet is fed byte-by-byte into the UART transmitter over a valid/ready handshake. The block sits directly upstream of the UART transmit stage, between the hall-speed counters and the serial link.

## Interface
- PERIOD_CYCLES, 1000000: packet trigger interval in CLK cycles (100 Hz at 100 MHz); legal range 16 to 2^24.
- HDR0, 8'hAA: first header byte.
- HDR1, 8'h55: second header byte.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  high enables periodic triggering.
- SPEED0..SPEED3  in  16 each  hall-speed counts for motors 0..3.
- TX_DATA  out  8  byte offered to the UART transmitter.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  UART transmitter can accept a byte.
- BUSY  out  1  a packet is in progress.
- PKT_DONE  out  1  one-cycle pulse when the last byte is accepted.
- OVERRUN  out  1  sticky: a trigger fired while BUSY.

## Operation
- Packet byte order, index 0..11: HDR0, HDR1, SEQ, S0[15:8], S0[7:0], S1[15:8], S1[7:0], S2[15:8], S2[7:0], S3[15:8], S3[7:0], CHK.
- CHK is the 8-bit modular sum of bytes 2..10; carries are discarded.
- SEQ is an 8-bit counter that increments by 1 on each PKT_DONE and wraps 0xFF to 0x00.
- Period counter (24-bit):
  - While ENABLE is low, it is held at 0 and no trigger is generated.
  - While ENABLE is high, it increments each cycle.
  - At PERIOD_CYCLES-1 it asserts an internal trigger for one cycle and wraps to 0.
- FSM states IDLE and SEND:
  - IDLE + trigger: register SPEED0..3 and SEQ into the snapshot, set idx=0, go to SEND.
  - SEND: TX_VALID=1 and TX_DATA=byte[idx] of the snapshot.
  - SEND, on a TX_VALID&&TX_READY cycle with idx<11: idx increments.
  - SEND, on a TX_VALID&&TX_READY cycle with idx==11: go to IDLE, pulse PKT_DONE, increment SEQ.
- A trigger in any cycle where state != IDLE, including the final-handshake cycle, is dropped and sets OVERRUN. OVERRUN clears only on RST.
- ENABLE falling mid-packet does not abort; the current packet completes.
- SPEED inputs changing during SEND have no effect on the packet in flight.

## Timing
- Reset values:
  - Outputs: TX_DATA=8'h00, TX_VALID=0, BUSY=0, PKT_DONE=0, OVERRUN=0.
  - Internal: SEQ=0, period counter=0, state IDLE.
- RST asserted mid-packet aborts the packet; TX_VALID is 0 after that edge and no PKT_DONE is issued.
- Latency: trigger in cycle T; TX_VALID=1 with TX_DATA=HDR0 in cycle T+1. BUSY=1 from T+1 through the final-handshake cycle.
- Handshake:
  - A byte transfers on any cycle with TX_VALID&&TX_READY.
  - While TX_VALID&&!TX_READY, TX_DATA holds stable.
  - TX_VALID never drops mid-packet.
- Throughput: with TX_READY tied high, a packet occupies exactly 12 consecutive cycles and bytes transfer back-to-back.
- PKT_DONE is asserted in the cycle after the final handshake, coincident with BUSY=0 and TX_VALID=0.
- First trigger arrives in the PERIOD_CYCLES-th cycle after ENABLE is sampled high.

## Test plan
- PERIOD_CYCLES=16, TX_READY=1, SPEED0..3=0x1234/0xABCD/0x0001/0xFFFF, after reset -> bytes AA 55 00 12 34 AB CD 00 01 FF FF BD; PKT_DONE pulses once; next packet has SEQ=01.
- TX_READY toggled with a pseudo-random pattern (≈30% high) -> identical byte sequence, TX_DATA stable during every stall, no dropped or duplicated byte.
- TX_READY held low past the next trigger -> OVERRUN=1 and stays 1; the in-flight packet still completes unchanged; the dropped trigger produces no packet.
- SPEED inputs changed every cycle during SEND -> emitted bytes match the values sampled in the trigger cycle.
- RST pulsed at idx=5 -> TX_VALID=0, BUSY=0, SEQ=0 next cycle; the next packet starts at HDR0 with SEQ=00.
- 256+ packets -> SEQ wraps FF→00; CHK correct for every packet; ENABLE=0 -> no further triggers and counter held at 0.
